pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It combines three hazard sources into per-stage pipeline-register controls: the EX-stage taken-branch signal, load-use hazards detected at ID/EX, and data-memory wait states in MEM. A small state machine tracks multi-cycle memory waits and raises a sticky fault on timeout. Saturating performance counters record flush and stall cycles.

## Interface
- `TIMEOUT`, default 16: consecutive not-ready MEM cycles before a fault; legal range 2..255.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `taken_branch`  in  1  branch/jump resolved taken in EX this cycle.
- `ex_mem_read`  in  1  instruction in ID/EX is a load.
- `ex_rd`  in  5  destination register of the ID/EX instruction.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the IF/ID instruction.
- `mem_req`  in  1  instruction in MEM accesses data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`  out  1  PC register load enable.
- `if_id_en`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  IF/ID loads a NOP.
- `id_ex_en`  out  1  ID/EX register load enable.
- `id_ex_flush`  out  1  ID/EX loads a NOP.
- `ex_mem_en`  out  1  EX/MEM register load enable.
- `mem_wb_bubble`  out  1  MEM/WB loads a NOP instead of the MEM result.
- `fault`  out  1  sticky memory-timeout error.
- `flush_cnt`  out  CNT_W  count of applied branch-flush cycles.
- `stall_cnt`  out  CNT_W  count of applied load-use stall cycles.

## Operation
- States: RUN, MEM_WAIT, FAULT. Reset sets state to RUN, `wait_cnt` to 0, and both counters to 0.
- Controls are combinational from the current state and inputs. The default in RUN and MEM_WAIT is: all enables 1, all flush/bubble signals 0.
- `miss` = `mem_req` & !`mem_ready`.
- `lu_hz` = `ex_mem_read` & (`ex_rd` != 0) & (`ex_rd`==`id_rs1` | `ex_rd`==`id_rs2`).
- Priority, highest first:
  1. FAULT: `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0; `mem_wb_bubble` = 1; `fault` = 1.
  2. `miss` (RUN or MEM_WAIT): freeze. `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0 and `mem_wb_bubble` = 1. Branch and load-use actions are suppressed and counters hold. EX is frozen, so `taken_branch` re-presents after the wait and is then acted on.
  3. `taken_branch`: `if_id_flush` = 1 and `id_ex_flush` = 1, all enables 1. This overrides `lu_hz`, because the stalled instruction is squashed anyway.
  4. `lu_hz`: `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1. EX/MEM and MEM/WB advance.
- Transitions:
  - RUN: on `miss`, go to MEM_WAIT and set `wait_cnt` ← 1.
  - MEM_WAIT: if !`miss`, go to RUN and set `wait_cnt` ← 0. Else if `wait_cnt` == TIMEOUT−1, go to FAULT. Else increment `wait_cnt`.
  - FAULT: absorbing until `rst`.
  - A `mem_req` deassert while in MEM_WAIT counts as completion.
- Counters:
  - `flush_cnt` increments on each cycle where rule 3 applies.
  - `stall_cnt` increments on each cycle where rule 4 applies.
  - Both saturate at all-ones and never wrap.
- `wait_cnt` width is clog2(TIMEOUT).

## Timing
- Control outputs have zero latency: they are valid in the same cycle as their inputs, with no registered delay.
- `fault`, `flush_cnt`, and `stall_cnt` are registered and update on the edge after the triggering cycle.
- Exactly TIMEOUT consecutive `miss` cycles are tolerated. `fault` = 1 appears on the following cycle.
- A `miss` cycle that is immediately followed by a ready cycle costs 1 stall cycle and returns to RUN.
- A `rst` asserted mid-wait or in FAULT returns to RUN on the next edge: `fault` = 0, counters = 0.
- Reset values: `fault` = 0, `flush_cnt` = 0, `stall_cnt` = 0. Combinational outputs follow RUN rules with the live inputs.

## Test plan
- Taken branch, no other hazard. Drive `taken_branch` = 1 for 1 cycle → `if_id_flush` = `id_ex_flush` = 1 and all enables 1 that cycle; `flush_cnt` = 1 next cycle.
- Load-use. `ex_mem_read` = 1, `ex_rd` = 5, `id_rs2` = 5 → `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1, `stall_cnt` +1. Repeat with `ex_rd` = 0 → no stall.
- Branch plus load-use in the same cycle → flush action only; `stall_cnt` unchanged, `flush_cnt` +1.
- Memory wait with branch pending. `mem_req` = 1, `mem_ready` = 0 for 3 cycles while `taken_branch` = 1 → freeze and bubble for 3 cycles with no flush. On the 4th cycle (`mem_ready` = 1), the flush applies and `flush_cnt` = 1.
- Timeout with TIMEOUT = 4. Hold `miss` → stall cycles 0–3, `fault` = 1 from cycle 4, everything frozen. Assert `rst` → `fault` = 0, state RUN next cycle.
- Counter saturation with CNT_W = 4. Apply 20 flush cycles → `flush_cnt` stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges taken-branch, load-use
// and data-memory wait hazards into per-stage register controls.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             taken_branch,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             fault,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0]    WAIT_ONE  = 1;
    localparam logic [WW-1:0]    WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

    state_t         state;
    logic [WW-1:0]  wait_cnt;
    logic           miss;
    logic           lu_hz;
    logic           do_flush;
    logic           do_stall;

    assign miss  = mem_req & ~mem_ready;
    assign lu_hz = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // A memory freeze holds EX, so a pending branch is acted on only once the wait ends.
    assign do_flush = (state != FAULT) & ~miss & taken_branch;
    assign do_stall = (state != FAULT) & ~miss & ~taken_branch & lu_hz;

    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        mem_wb_bubble = 1'b0;
        if (state == FAULT || miss) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (taken_branch) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (lu_hz) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            fault     <= 1'b0;
            flush_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (miss) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (!miss) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
            if (do_flush && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_ONE;
            if (do_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short timeout and narrow counters
// so that fault and saturation behaviour are reachable in few cycles.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    // Control bundle order: pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble
    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_STALL  = 7'b0001110;
    localparam logic [6:0] C_FREEZE = 7'b0000001;

    logic             clk = 1'b0;
    logic             rst;
    logic             taken_branch;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic             fault;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [6:0]       ctrl;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .taken_branch(taken_branch), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_bubble(mem_wb_bubble), .fault(fault),
        .flush_cnt(flush_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble};

    task automatic applyStimulus(input logic tb, input logic lr, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic req, input logic rdy);
        taken_branch = tb;
        ex_mem_read  = lr;
        ex_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        mem_req      = req;
        mem_ready    = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        doReset();

        checkOutput("reset_fault", 32'(fault), 0);
        checkOutput("reset_flush_cnt", 32'(flush_cnt), 0);
        checkOutput("reset_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("reset_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Taken branch alone
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("branch_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("branch_flush_cnt", 32'(flush_cnt), 1);
        checkOutput("idle_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Load-use on rs2, then x0 destination, then rs1
        applyStimulus(0, 1, 5, 0, 5, 0, 0);
        checkOutput("lu_rs2_ctrl", 32'(ctrl), 32'(C_STALL));
        tick();
        checkOutput("lu_rs2_stall_cnt", 32'(stall_cnt), 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checkOutput("lu_x0_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();
        checkOutput("lu_x0_stall_cnt", 32'(stall_cnt), 1);
        applyStimulus(0, 1, 7, 7, 2, 0, 0);
        checkOutput("lu_rs1_ctrl", 32'(ctrl), 32'(C_STALL));
        applyStimulus(0, 0, 7, 7, 2, 0, 0);
        checkOutput("no_load_ctrl", 32'(ctrl), 32'(C_NORMAL));
        applyStimulus(0, 1, 7, 7, 2, 0, 0);
        tick();
        checkOutput("lu_rs1_stall_cnt", 32'(stall_cnt), 2);

        // Branch overrides load-use
        applyStimulus(1, 1, 3, 3, 0, 0, 0);
        checkOutput("br_lu_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        checkOutput("br_lu_flush_cnt", 32'(flush_cnt), 2);
        checkOutput("br_lu_stall_cnt", 32'(stall_cnt), 2);

        // Memory wait with a pending branch: freeze 3 cycles, then flush
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("memwait_ctrl_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            tick();
            checkOutput($sformatf("memwait_flush_cnt_%0d", i), 32'(flush_cnt), 2);
            checkOutput($sformatf("memwait_fault_%0d", i), 32'(fault), 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 1, 1);
        checkOutput("memdone_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        checkOutput("memdone_flush_cnt", 32'(flush_cnt), 3);

        // Single miss then ready; then miss ended by mem_req dropping
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("single_miss_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        checkOutput("single_ready_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("req_drop_ctrl", 32'(ctrl), 32'(C_NORMAL));
        tick();
        checkOutput("req_drop_fault", 32'(fault), 0);

        // Three more misses after a recovery must not fault: wait_cnt restarted
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("restart_no_fault", 32'(fault), 0);

        // Timeout: TIMEOUT miss cycles tolerated, fault on the next
        for (int i = 0; i < TIMEOUT; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            checkOutput($sformatf("timeout_ctrl_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            checkOutput($sformatf("timeout_prefault_%0d", i), 32'(fault), 0);
            tick();
        end
        checkOutput("timeout_fault", 32'(fault), 1);
        applyStimulus(1, 1, 4, 4, 0, 0, 0);
        checkOutput("fault_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick();
        checkOutput("fault_sticky", 32'(fault), 1);
        checkOutput("fault_flush_hold", 32'(flush_cnt), 3);
        checkOutput("fault_stall_hold", 32'(stall_cnt), 2);

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        checkOutput("postrst_fault", 32'(fault), 0);
        checkOutput("postrst_flush_cnt", 32'(flush_cnt), 0);
        checkOutput("postrst_stall_cnt", 32'(stall_cnt), 0);
        checkOutput("postrst_ctrl", 32'(ctrl), 32'(C_NORMAL));

        // Counter saturation
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            tick();
            checkOutput($sformatf("sat_flush_%0d", i), 32'(flush_cnt), (i + 1 > 15) ? 15 : i + 1);
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1, 9, 1, 9, 0, 0);
            tick();
            checkOutput($sformatf("sat_stall_%0d", i), 32'(stall_cnt), (i + 1 > 15) ? 15 : i + 1);
        end
        checkOutput("sat_flush_final", 32'(flush_cnt), 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
